// File: rtl/select_encode_writeback_if.sv
// Control/bus bundle between the sequencer, select/encode/write-back block and register file.
// master = controller side driving requests; slave = select_encode_writeback.
interface select_encode_writeback_if #(
  parameter int DW   = 32,
  parameter int NREG = 16
);
  logic [DW-1:0]   bus_in;
  logic            ir_ld;
  logic            gra;
  logic            grb;
  logic            grc;
  logic            r_out;
  logic            ba_out;
  logic            r_in;
  logic            r_in_ready;
  logic            rf_ready;
  logic [NREG-1:0] r_sel_out;
  logic            r0_zero;
  logic [NREG-1:0] wr_en;
  logic [DW-1:0]   wr_data;
  logic            raw_hazard;
  logic [DW-1:0]   ir_q;
  logic [DW-1:0]   c_sign_extended;

  modport master (
    output bus_in, ir_ld, gra, grb, grc, r_out, ba_out, r_in, rf_ready,
    input  r_in_ready, r_sel_out, r0_zero, wr_en, wr_data, raw_hazard, ir_q, c_sign_extended
  );

  modport slave (
    input  bus_in, ir_ld, gra, grb, grc, r_out, ba_out, r_in, rf_ready,
    output r_in_ready, r_sel_out, r0_zero, wr_en, wr_data, raw_hazard, ir_q, c_sign_extended
  );
endinterface

// File: rtl/select_encode_writeback.sv
// IR + Ra/Rb/Rc one-hot select decode (combinational), C sign-extend, one-entry write-back buffer.
// Writes drain the cycle after accept; rf_ready low holds the entry and drops r_in_ready when full.
module select_encode_writeback #(
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input logic                 clk,
  input logic                 clr,
  select_encode_writeback_if.slave sel_if
);

  logic [DW-1:0] r_ir;
  logic          r_buf_vld;
  logic [3:0]    r_buf_idx;
  logic [DW-1:0] r_buf_dat;

  logic          w_sel_any;
  logic [3:0]    w_idx;
  logic          w_drive;
  logic          w_r0_zero;
  logic          w_accept;
  logic          w_drain;
  logic          w_in_ready;

  assign w_sel_any = sel_if.gra | sel_if.grb | sel_if.grc;

  always_comb begin
    w_idx = r_ir[18:15];
    if (sel_if.gra)
      w_idx = r_ir[26:23];
    else if (sel_if.grb)
      w_idx = r_ir[22:19];
  end

  assign w_drive   = sel_if.r_out | sel_if.ba_out;
  // BAout on R0 reads as constant zero; r_out alone still selects R0.
  assign w_r0_zero = w_sel_any & sel_if.ba_out & (w_idx == 4'd0);

  assign sel_if.r_sel_out = (w_sel_any & w_drive & !w_r0_zero) ? (NREG'(1) << w_idx) : '0;
  assign sel_if.r0_zero   = w_r0_zero;

  assign w_in_ready = !r_buf_vld | sel_if.rf_ready;
  assign w_accept   = sel_if.r_in & w_sel_any & w_in_ready;
  assign w_drain    = r_buf_vld & sel_if.rf_ready;

  assign sel_if.r_in_ready = w_in_ready;
  assign sel_if.wr_en      = w_drain ? (NREG'(1) << r_buf_idx) : '0;
  assign sel_if.wr_data    = r_buf_vld ? r_buf_dat : '0;
  // Flag even while the entry drains: the register file has not been updated yet this cycle.
  assign sel_if.raw_hazard = r_buf_vld & w_drive & w_sel_any & (r_buf_idx == w_idx);

  assign sel_if.ir_q            = r_ir;
  assign sel_if.c_sign_extended = {{(DW-19){r_ir[18]}}, r_ir[18:0]};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ir      <= '0;
      r_buf_vld <= 1'b0;
      r_buf_idx <= '0;
      r_buf_dat <= '0;
    end else begin
      if (sel_if.ir_ld)
        r_ir <= sel_if.bus_in;
      // Accept and drain may coincide: the new entry replaces the draining one without a bubble.
      if (w_accept) begin
        r_buf_vld <= 1'b1;
        r_buf_idx <= w_idx;
        r_buf_dat <= sel_if.bus_in;
      end else if (w_drain) begin
        r_buf_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_select_encode_writeback.sv
// Directed-vector bench for select_encode_writeback: decode, sign extension, write handshake, stall, hazard, reset.
module tb_select_encode_writeback;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  select_encode_writeback_if #(.DW(32), .NREG(16)) bus_if ();

  select_encode_writeback #(.DW(32), .NREG(16)) dut (
    .clk    (clk),
    .clr    (clr),
    .sel_if (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 4 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    bus_if.ir_ld  = 1'b0;
    bus_if.gra    = 1'b0;
    bus_if.grb    = 1'b0;
    bus_if.grc    = 1'b0;
    bus_if.r_out  = 1'b0;
    bus_if.ba_out = 1'b0;
    bus_if.r_in   = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] v);
    idle();
    bus_if.bus_in = v;
    bus_if.ir_ld  = 1'b1;
    step();
    bus_if.ir_ld  = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    idle();
    bus_if.bus_in   = 32'h0;
    bus_if.rf_ready = 1'b1;
    #7;
    n_checks++; if (bus_if.ir_q !== 32'h0) begin n_fail++; $display("FAIL reset_ir_q got %h exp %h", bus_if.ir_q, 32'h0); end
    n_checks++; if (bus_if.wr_en !== 16'h0) begin n_fail++; $display("FAIL reset_wr_en got %h exp %h", bus_if.wr_en, 16'h0); end
    n_checks++; if (bus_if.wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data got %h exp %h", bus_if.wr_data, 32'h0); end
    clr = 1'b1;
    step();
    n_checks++; if (bus_if.r_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_r_in_ready got %b exp 1", bus_if.r_in_ready); end
  endtask

  task automatic test_ir_decode();
    load_ir(32'h19AB8005);
    bus_if.gra = 1'b1; bus_if.r_out = 1'b1;
    settle();
    n_checks++; if (bus_if.ir_q !== 32'h19AB8005) begin n_fail++; $display("FAIL ir_load got %h exp %h", bus_if.ir_q, 32'h19AB8005); end
    n_checks++; if (bus_if.r_sel_out !== 16'h0008) begin n_fail++; $display("FAIL decode_ra got %h exp %h", bus_if.r_sel_out, 16'h0008); end
    bus_if.gra = 1'b0; bus_if.grb = 1'b1;
    #1;
    n_checks++; if (bus_if.r_sel_out !== 16'h0020) begin n_fail++; $display("FAIL decode_rb got %h exp %h", bus_if.r_sel_out, 16'h0020); end
    bus_if.grb = 1'b0; bus_if.grc = 1'b1;
    #1;
    n_checks++; if (bus_if.r_sel_out !== 16'h0080) begin n_fail++; $display("FAIL decode_rc got %h exp %h", bus_if.r_sel_out, 16'h0080); end
    n_checks++; if (bus_if.c_sign_extended !== 32'h00038005) begin n_fail++; $display("FAIL c_pos got %h exp %h", bus_if.c_sign_extended, 32'h00038005); end
    bus_if.gra = 1'b1; bus_if.grb = 1'b1;
    #1;
    n_checks++; if (bus_if.r_sel_out !== 16'h0008) begin n_fail++; $display("FAIL decode_priority got %h exp %h", bus_if.r_sel_out, 16'h0008); end
    idle(); bus_if.ba_out = 1'b1; bus_if.gra = 1'b1;
    #1;
    n_checks++; if (bus_if.r_sel_out !== 16'h0008 || bus_if.r0_zero !== 1'b0) begin n_fail++; $display("FAIL ba_nonzero got sel=%h z=%b exp sel=0008 z=0", bus_if.r_sel_out, bus_if.r0_zero); end
    idle(); bus_if.r_out = 1'b1;
    #1;
    n_checks++; if (bus_if.r_sel_out !== 16'h0000) begin n_fail++; $display("FAIL no_field_sel got %h exp %h", bus_if.r_sel_out, 16'h0000); end
    idle();
  endtask

  task automatic test_sign_ext_baout();
    load_ir(32'h0007FFFF);
    bus_if.grb = 1'b1; bus_if.ba_out = 1'b1;
    settle();
    n_checks++; if (bus_if.c_sign_extended !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL c_neg got %h exp %h", bus_if.c_sign_extended, 32'hFFFFFFFF); end
    n_checks++; if (bus_if.r0_zero !== 1'b1) begin n_fail++; $display("FAIL ba_r0_zero got %b exp 1", bus_if.r0_zero); end
    n_checks++; if (bus_if.r_sel_out !== 16'h0000) begin n_fail++; $display("FAIL ba_r0_sel got %h exp %h", bus_if.r_sel_out, 16'h0000); end
    bus_if.ba_out = 1'b0; bus_if.r_out = 1'b1;
    #1;
    n_checks++; if (bus_if.r_sel_out !== 16'h0001 || bus_if.r0_zero !== 1'b0) begin n_fail++; $display("FAIL rout_r0 got sel=%h z=%b exp sel=0001 z=0", bus_if.r_sel_out, bus_if.r0_zero); end
    idle();
  endtask

  task automatic test_write_ready();
    load_ir(32'h19AB8005);
    bus_if.rf_ready = 1'b1;
    bus_if.gra = 1'b1; bus_if.r_in = 1'b1; bus_if.bus_in = 32'hDEADBEEF;
    settle();
    n_checks++; if (bus_if.r_in_ready !== 1'b1 || bus_if.wr_en !== 16'h0) begin n_fail++; $display("FAIL wr_pre got rdy=%b en=%h exp rdy=1 en=0000", bus_if.r_in_ready, bus_if.wr_en); end
    step();
    idle();
    settle();
    n_checks++; if (bus_if.wr_en !== 16'h0008) begin n_fail++; $display("FAIL wr_en got %h exp %h", bus_if.wr_en, 16'h0008); end
    n_checks++; if (bus_if.wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data got %h exp %h", bus_if.wr_data, 32'hDEADBEEF); end
    step();
    settle();
    n_checks++; if (bus_if.wr_en !== 16'h0 || bus_if.wr_data !== 32'h0) begin n_fail++; $display("FAIL wr_one_cycle got en=%h dat=%h exp en=0000 dat=0", bus_if.wr_en, bus_if.wr_data); end
  endtask

  task automatic test_no_field_write();
    bus_if.rf_ready = 1'b1;
    bus_if.r_in = 1'b1; bus_if.bus_in = 32'h55;
    step();
    idle();
    settle();
    n_checks++; if (bus_if.wr_en !== 16'h0 || bus_if.wr_data !== 32'h0) begin n_fail++; $display("FAIL no_field_write got en=%h dat=%h exp en=0000 dat=0", bus_if.wr_en, bus_if.wr_data); end
  endtask

  task automatic test_stall();
    bus_if.rf_ready = 1'b0;
    bus_if.gra = 1'b1; bus_if.r_in = 1'b1; bus_if.bus_in = 32'h11;
    step();
    bus_if.gra = 1'b0; bus_if.grb = 1'b1; bus_if.bus_in = 32'h22;
    settle();
    n_checks++; if (bus_if.r_in_ready !== 1'b0 || bus_if.wr_en !== 16'h0) begin n_fail++; $display("FAIL stall_1 got rdy=%b en=%h exp rdy=0 en=0000", bus_if.r_in_ready, bus_if.wr_en); end
    step();
    settle();
    n_checks++; if (bus_if.r_in_ready !== 1'b0 || bus_if.wr_en !== 16'h0 || bus_if.wr_data !== 32'h11) begin n_fail++; $display("FAIL stall_2 got rdy=%b en=%h dat=%h exp rdy=0 en=0000 dat=11", bus_if.r_in_ready, bus_if.wr_en, bus_if.wr_data); end
    bus_if.rf_ready = 1'b1;
    #1;
    n_checks++; if (bus_if.r_in_ready !== 1'b1 || bus_if.wr_en !== 16'h0008 || bus_if.wr_data !== 32'h11) begin n_fail++; $display("FAIL stall_drain1 got rdy=%b en=%h dat=%h exp rdy=1 en=0008 dat=11", bus_if.r_in_ready, bus_if.wr_en, bus_if.wr_data); end
    step();
    idle();
    settle();
    n_checks++; if (bus_if.wr_en !== 16'h0020 || bus_if.wr_data !== 32'h22) begin n_fail++; $display("FAIL back_to_back got en=%h dat=%h exp en=0020 dat=22", bus_if.wr_en, bus_if.wr_data); end
    step();
    settle();
    n_checks++; if (bus_if.wr_en !== 16'h0) begin n_fail++; $display("FAIL stall_empty got %h exp %h", bus_if.wr_en, 16'h0); end
  endtask

  task automatic test_hazard();
    bus_if.rf_ready = 1'b0;
    bus_if.gra = 1'b1; bus_if.r_in = 1'b1; bus_if.bus_in = 32'h33;
    step();
    idle();
    bus_if.gra = 1'b1; bus_if.r_out = 1'b1;
    settle();
    n_checks++; if (bus_if.raw_hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_r3 got %b exp 1", bus_if.raw_hazard); end
    bus_if.gra = 1'b0; bus_if.grb = 1'b1;
    #1;
    n_checks++; if (bus_if.raw_hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_r5 got %b exp 0", bus_if.raw_hazard); end
    bus_if.grb = 1'b0; bus_if.gra = 1'b1; bus_if.rf_ready = 1'b1;
    #1;
    n_checks++; if (bus_if.raw_hazard !== 1'b1 || bus_if.wr_en !== 16'h0008) begin n_fail++; $display("FAIL hazard_draining got hz=%b en=%h exp hz=1 en=0008", bus_if.raw_hazard, bus_if.wr_en); end
    step();
    settle();
    n_checks++; if (bus_if.raw_hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_cleared got %b exp 0", bus_if.raw_hazard); end
    idle();
  endtask

  task automatic test_reset_mid();
    bus_if.rf_ready = 1'b0;
    bus_if.grb = 1'b1; bus_if.r_in = 1'b1; bus_if.bus_in = 32'h77;
    step();
    idle();
    #2;
    clr = 1'b0;
    #1;
    n_checks++; if (bus_if.ir_q !== 32'h0 || bus_if.r_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid got ir=%h rdy=%b exp ir=0 rdy=1", bus_if.ir_q, bus_if.r_in_ready); end
    #3;
    clr = 1'b1;
    bus_if.rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus_if.wr_en !== 16'h0 || bus_if.r_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_discard[%0d] got en=%h rdy=%b exp en=0000 rdy=1", i, bus_if.wr_en, bus_if.r_in_ready); end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ir_decode();
    test_sign_ext_baout();
    test_write_ready();
    test_no_field_write();
    test_stall();
    test_hazard();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/select_encode_writeback.md
Name: select_encode_writeback

Overview:
- Control-side companion to the bus multiplexer.
- Holds the instruction register (IR) and decodes its Ra/Rb/Rc fields into the one-hot R0–R15 bus-drive selects that steer the mux.
- Produces the sign-extended C constant that the mux places on the bus.
- Accepts bus writes into R0–R15 through a one-entry write-back buffer with a valid/ready handshake toward a register file that may stall.

Parameters:
- DW, 32, bus/register data width
- NREG, 16, number of general registers (fixed by the 4-bit IR fields)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- bus_in  in  DW  shared bus value
- ir_ld  in  1  load IR from bus_in
- gra  in  1  select Ra field (IR[26:23])
- grb  in  1  select Rb field (IR[22:19])
- grc  in  1  select Rc field (IR[18:15])
- r_out  in  1  selected register drives bus
- ba_out  in  1  base-address drive; selecting R0 yields zero
- r_in  in  1  write request: bus_in to selected register (valid)
- r_in_ready  out  1  write request accepted this cycle
- rf_ready  in  1  register file can take a write this cycle
- r_sel_out  out  NREG  one-hot drive select to the mux
- r0_zero  out  1  mux must drive zero (BAout with R0)
- wr_en  out  NREG  one-hot register write strobe
- wr_data  out  DW  data for wr_en
- raw_hazard  out  1  selected register has a pending buffered write
- ir_q  out  DW  current IR
- c_sign_extended  out  DW  IR[18:0] sign-extended from bit 18

Behaviour:
- Reset (clr low, asynchronous): ir_q=0, buffer empty, wr_en=0, wr_data=0; r_in_ready=1 once clr is released.
- IR register:
  - ir_ld high at a rising edge: ir_q <= bus_in.
  - ir_ld has priority over nothing else; IR is independent of the write path.
- Field decode (combinational from ir_q):
  - Priority gra > grb > grc gives a 4-bit index idx.
  - None asserted: no select, so r_sel_out=0 and no write is possible.
- Read select (combinational, same cycle):
  - r_sel_out[idx]=1 when (r_out | ba_out).
  - Exception: ba_out with idx=0 gives r_sel_out=0 and r0_zero=1.
  - r_out alone with idx=0 selects R0 normally.
- Write handshake:
  - Accept condition: r_in & field selected & r_in_ready.
  - r_in_ready = !buf_valid | rf_ready.
  - On accept at edge N: buffer <= {idx, bus_in}, buf_valid=1.
  - r_in with no field selected is ignored (not accepted, nothing buffered).
- Drain:
  - wr_en = onehot(buf_idx) & {NREG{buf_valid & rf_ready}}; wr_data = buf_data whenever buf_valid, else 0.
  - Write lands in the register file at the edge where wr_en is high.
  - Minimum latency: the cycle after accept.
  - rf_ready low: the entry is held indefinitely and wr_en stays 0.
- Simultaneous drain and accept in the same cycle: the old entry drains (wr_en high) and the new entry is loaded at the same edge; no bubble.
- Full buffer with rf_ready low: r_in_ready=0, and the request must be held by the controller.
- raw_hazard = buf_valid & (r_out|ba_out) & field selected & (buf_idx==idx); asserted even if that entry is draining this cycle.
- Writes to R0 are legal; only the ba_out read path masks R0.
- Reset mid-operation: the pending buffered write is discarded and never appears on wr_en.

Test Plan:
- IR decode:
  - Stimulus: bus_in=0x19AB8005, ir_ld=1, then gra+r_out.
  - Required: r_sel_out=0x0008; with grb, 0x0020; with grc, 0x0080; c_sign_extended=0x00038005.
- Sign extension / BAout:
  - Stimulus: IR=0x0007FFFF, grb+ba_out.
  - Required: c_sign_extended=0xFFFFFFFF, r0_zero=1, r_sel_out=0.
  - Then grb+r_out gives r_sel_out=0x0001, r0_zero=0.
- Write with ready:
  - Stimulus: IR=0x19AB8005, gra+r_in, bus_in=0xDEADBEEF, rf_ready=1.
  - Required: next cycle wr_en=0x0008, wr_data=0xDEADBEEF for exactly one cycle.
- Stall:
  - Stimulus: rf_ready=0; write 0x11 to R3, then request a write of 0x22 to R5.
  - Required: r_in_ready=0 and wr_en=0 while stalled.
  - Raise rf_ready: wr_en=0x0008/0x11, then the next cycle wr_en=0x0020/0x22.
- Hazard: buffered write to R3 held, plus gra+r_out on R3 gives raw_hazard=1; grb+r_out on R5 gives raw_hazard=0.
- Reset mid-operation: entry buffered with rf_ready=0, pulse clr low asynchronously (mid-cycle), then raise rf_ready. Required: wr_en stays 0, ir_q=0, r_in_ready=1.
